// File: rtl/uart_pkg.sv
// Shared UART types and constants: FSM state encodings, frame width and
// oversampling tick positions used by the echo block.
package uart_pkg;

    localparam int unsigned DATA_BITS      = 8;
    localparam int unsigned OVERSAMPLE_DEF = 16;
    localparam int unsigned MID            = OVERSAMPLE_DEF / 2 - 1;
    localparam int unsigned LAST           = OVERSAMPLE_DEF - 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    typedef enum logic [1:0] {
        RX_IDLE  = ST_IDLE,
        RX_START = ST_START,
        RX_DATA  = ST_DATA,
        RX_STOP  = ST_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = ST_IDLE,
        TX_START = ST_START,
        TX_DATA  = ST_DATA,
        TX_STOP  = ST_STOP
    } tx_state_t;

    // Tick index of the mid-start sample and of the last tick of a bit.
    function automatic int unsigned tick_mid(input int unsigned os);
        return os / 2 - 1;
    endfunction

    function automatic int unsigned tick_last(input int unsigned os);
        return os - 1;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversampling tick generator: one-clock pulse every
// CLK_FREQ/(BAUD_RATE*OVERSAMPLE) clocks, shared by RX and TX.
module uart_baud_gen #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    localparam int unsigned DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        tick_d = (cnt_q == DIV_LAST);
        cnt_d  = tick_d ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/uart_echo_top.sv
// UART 8N1 loopback: oversampling receiver -> echo FIFO -> transmitter.
// Define UART_FRAME_CHECK_EN to drop bytes whose stop bit samples low.
module uart_echo_top
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic tx
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] T_MID  = TW'(tick_mid(OVERSAMPLE));
    localparam logic [TW-1:0] T_LAST = TW'(tick_last(OVERSAMPLE));
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic tick;

    uart_baud_gen #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_baud (
        .clk_i (clk),
        .rst_ni(rst),
        .tick_o(tick)
    );

    // ---------------- receiver ----------------
    logic                 rx_s1_q, rx_s2_q;
    rx_state_t            rx_state_q, rx_state_d;
    logic [TW-1:0]        rx_tick_q, rx_tick_d;
    logic [BW-1:0]        rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_hold_q, rx_hold_d;
    logic                 push;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_tick_d  = rx_tick_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_hold_d  = rx_hold_q;
        push       = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_hold_q) begin
                    if (rx_s2_q) rx_hold_d = 1'b0;
                end else if (!rx_s2_q) begin
                    rx_tick_d  = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: if (tick) begin
                if (rx_tick_q == T_MID) begin
                    rx_tick_d  = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_tick_d = rx_tick_q + 1'b1;
                end
            end
            RX_DATA: if (tick) begin
                if (rx_tick_q == T_LAST) begin
                    rx_tick_d  = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == LAST_BIT) rx_state_d = RX_STOP;
                end else begin
                    rx_tick_d = rx_tick_q + 1'b1;
                end
            end
            RX_STOP: if (tick) begin
                if (rx_tick_q == T_LAST) begin
                    rx_tick_d  = '0;
                    rx_state_d = RX_IDLE;
`ifdef UART_FRAME_CHECK_EN
                    if (rx_s2_q) push = 1'b1;
                    else         rx_hold_d = 1'b1;
`else
                    push = 1'b1;
`endif
                end else begin
                    rx_tick_d = rx_tick_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_hold_q  <= 1'b0;
        end else begin
            rx_s1_q    <= rx;
            rx_s2_q    <= rx_s1_q;
            rx_state_q <= rx_state_d;
            rx_tick_q  <= rx_tick_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_hold_q  <= rx_hold_d;
        end
    end

    // ---------------- echo FIFO ----------------
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        fifo_cnt_q, fifo_cnt_d;
    logic                 push_ok, pop, fifo_empty;
    logic [DATA_BITS-1:0] fifo_head;

    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_head  = mem_q[rd_ptr_q];
    assign push_ok    = push && (fifo_cnt_q != FULL_CNT);

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        if (push_ok && !pop)      fifo_cnt_d = fifo_cnt_q + 1'b1;
        else if (!push_ok && pop) fifo_cnt_d = fifo_cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push_ok) mem_q[wr_ptr_q] <= rx_shift_q;
    end

    // ---------------- transmitter ----------------
    tx_state_t            tx_state_q, tx_state_d;
    logic [TW-1:0]        tx_tick_q, tx_tick_d;
    logic [BW-1:0]        tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_q, tx_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_tick_d  = tx_tick_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        pop        = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    tx_shift_d = fifo_head;
                    tx_tick_d  = '0;
                    tx_d       = 1'b0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: if (tick) begin
                if (tx_tick_q == T_LAST) begin
                    tx_tick_d  = '0;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                    tx_state_d = TX_DATA;
                end else begin
                    tx_tick_d = tx_tick_q + 1'b1;
                end
            end
            TX_DATA: if (tick) begin
                if (tx_tick_q == T_LAST) begin
                    tx_tick_d = '0;
                    if (tx_bit_q == LAST_BIT) begin
                        tx_d       = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_d       = tx_shift_q[1];
                    end
                end else begin
                    tx_tick_d = tx_tick_q + 1'b1;
                end
            end
            TX_STOP: if (tick) begin
                if (tx_tick_q == T_LAST) begin
                    tx_tick_d = '0;
                    // Chain straight into the next start bit to keep pace with back-to-back RX.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        tx_shift_d = fifo_head;
                        tx_d       = 1'b0;
                        tx_state_d = TX_START;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end else begin
                    tx_tick_d = tx_tick_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state_q <= TX_IDLE;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_tick_q  <= tx_tick_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
        end
    end

    assign tx = tx_q;

endmodule

// File: tb/tb_uart_echo_top.sv
// Scoreboard bench for uart_echo_top at a reduced clock (divisor 4, 64 clocks
// per bit); a serial driver queues expected echoes, a tx monitor checks them.
module tb_uart_echo_top;

    localparam int unsigned DIV   = 4;
    localparam int unsigned BIT   = DIV * 16;
    localparam int unsigned FRAME = 10 * BIT;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx  = 1'b1;
    logic tx;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    logic [7:0]  exp_q[$];
    logic        mon_en = 1'b1;

    uart_echo_top #(
        .CLK_FREQ  (16 * DIV * 10_000),
        .BAUD_RATE (10_000),
        .OVERSAMPLE(16),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx (rx),
        .tx (tx)
    );

    always #5 clk = ~clk;

    initial begin
        #(10 * 60_000);
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Monitor: recover each tx frame at mid-bit and compare against the queue.
    initial begin : monitor
        logic [7:0] got;
        logic [7:0] exp;
        logic       stopb;
        logic       aborted;
        forever begin
            @(negedge clk);
            if (mon_en && rst && tx === 1'b0) begin
                aborted = 1'b0;
                repeat (BIT / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk);
                    got[i] = tx;
                end
                repeat (BIT) @(negedge clk);
                stopb = tx;
                if (!mon_en) aborted = 1'b1;
                if (!aborted) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_frame: got %h, required no frame", got);
                    end else begin
                        exp = exp_q.pop_front();
                        vectors++;
                        if (got !== exp) begin
                            miscompares++;
                            $display("FAIL echo_data: got %h, required %h", got, exp);
                        end
                        vectors++;
                        if (stopb !== 1'b1) begin
                            miscompares++;
                            $display("FAIL echo_stop: got %b, required 1 (byte %h)", stopb, exp);
                        end
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input int unsigned stop_len,
                             input logic stop_val);
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stop_val;
        repeat (stop_len) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic check_quiet(input int unsigned n, input string name);
        logic seen_low;
        seen_low = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (tx !== 1'b1) seen_low = 1'b1;
        end
        vectors++;
        if (seen_low) begin
            miscompares++;
            $display("FAIL %s: tx left idle, required constant 1", name);
        end
    endtask

    task automatic drain(input string name);
        int unsigned n;
        n = 0;
        while (exp_q.size() != 0 && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s: %0d echoes outstanding, required 0", name, exp_q.size());
        end
        repeat (BIT) @(negedge clk);
    endtask

    logic [7:0] loop_bytes [10];
    logic [7:0] b2b_bytes  [3];

    initial begin
        int unsigned n;
        loop_bytes = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80, 8'h7E, 8'hC3, 8'h3C, 8'h96};
        b2b_bytes  = '{8'h00, 8'hFF, 8'hA5};

        // Reset: 10 clocks low, tx must already be high.
        repeat (10) @(negedge clk);
        vectors++;
        if (tx !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_tx: got %b, required 1", tx);
        end
        rst = 1'b1;
        check_quiet(2000, "idle_after_reset");

        // Single byte 8'h31.
        exp_q.push_back(8'h31);
        send_byte(8'h31, BIT, 1'b1);
        drain("single_31");

        // Directed loop of ten bytes, with idle gaps.
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(loop_bytes[i]);
            send_byte(loop_bytes[i], BIT, 1'b1);
            repeat (BIT) @(negedge clk);
        end
        drain("loop");

        // Short low pulse on idle rx, well before mid start bit.
        @(negedge clk);
        rx = 1'b0;
        repeat (12) @(negedge clk);
        rx = 1'b1;
        check_quiet(2 * FRAME, "glitch");

        // Back-to-back frames, no idle between stop and next start.
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(b2b_bytes[i]);
            send_byte(b2b_bytes[i], BIT, 1'b1);
        end
        drain("back_to_back");

        // Framing error: stop bit low for 3/4 bit so the trailing low is
        // rejected as a glitch rather than decoded as a new start bit.
`ifdef UART_FRAME_CHECK_EN
        send_byte(8'h5A, 3 * BIT / 4, 1'b0);
        check_quiet(2 * FRAME, "framing_error_dropped");
`else
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 3 * BIT / 4, 1'b0);
        drain("framing_error_echoed");
        check_quiet(FRAME, "framing_error_no_extra");
`endif

        // Reset during tx data bit 3 of 8'h35 (bit 3 = 0).
        mon_en = 1'b0;
        send_byte(8'h35, BIT, 1'b1);
        n = 0;
        while (tx !== 1'b0 && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (tx !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_frame_start: tx %b, required start bit 0", tx);
        end
        repeat (4 * BIT + BIT / 2) @(negedge clk);
        vectors++;
        if (tx !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_bit3: tx %b, required 0", tx);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (tx !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_midframe_tx: got %b, required 1", tx);
        end
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (dut.fifo_cnt_q !== '0) begin
            miscompares++;
            $display("FAIL reset_fifo_empty: count %0d, required 0", dut.fifo_cnt_q);
        end
        mon_en = 1'b1;
        check_quiet(2 * FRAME, "idle_after_midframe_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
